// File: rtl/seq_alu.sv
// seq_alu: registered ALU with iterative mul/divu/remu, NZCV flags and valid/ready handshakes
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       cmd,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             dz,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t st, nxt;
    logic [CW-1:0] cnt;
    logic [3:0] op;
    logic [WIDTH-1:0] a, b, q;
    logic accept, iter, is_mul, ge, c, v;
    logic [WIDTH:0] sum, dif, r_sh, r_df;
    logic [WIDTH-1:0] res, m_a, d_a, d_q, a_n, q_n, b_n, fin;
    assign in_ready = rst_n & ((st == IDLE) | ((st == DONE) & out_ready));
    assign accept = in_valid & in_ready;
    assign iter = (cmd == 4'b0011) | (cmd == 4'b1011) | (cmd == 4'b1110);
    assign busy = (st == BUSY);
    assign out_valid = (st == DONE);
    always_comb begin
        sum = {1'b0, in1} + {1'b0, in2};
        dif = {1'b0, in1} - {1'b0, in2};
        case (cmd)
            4'b0000: res = sum[WIDTH-1:0];
            4'b0010: res = dif[WIDTH-1:0];
            4'b0100: res = in1 & in2;
            4'b0101: res = in1 | in2;
            4'b0110: res = ~(in1 | in2);
            4'b0111: res = in1 ^ in2;
            4'b1000: res = in1 << in2;
            4'b1001: res = $unsigned($signed(in1) >>> in2);
            4'b1010: res = in1 >> in2;
            4'b1100: res = in2;
            4'b1101: res = in1;
            default: res = '0;
        endcase
        c = (cmd == 4'b0000) ? sum[WIDTH] : (cmd == 4'b0010) ? ~dif[WIDTH] : 1'b0;
        v = (cmd == 4'b0000) ? (in1[WIDTH-1] == in2[WIDTH-1]) && (sum[WIDTH-1] != in1[WIDTH-1]) :
            (cmd == 4'b0010) ? (in1[WIDTH-1] != in2[WIDTH-1]) && (dif[WIDTH-1] != in1[WIDTH-1]) : 1'b0;
    end
    // a/b/q double as acc/multiplicand/multiplier for mul and rem/divisor/quotient for div
    always_comb begin
        is_mul = (op == 4'b0011);
        m_a = a + (q[0] ? b : '0);
        r_sh = {a, q[WIDTH-1]};
        r_df = r_sh - {1'b0, b};
        ge = ~r_df[WIDTH];
        d_a = ge ? r_df[WIDTH-1:0] : r_sh[WIDTH-1:0];
        d_q = {q[WIDTH-2:0], ge};
        a_n = is_mul ? m_a : d_a;
        q_n = is_mul ? q >> 1 : d_q;
        b_n = is_mul ? b << 1 : b;
        fin = (op == 4'b1011) ? d_q : a_n;
    end
    always_comb begin
        nxt = st;
        nxt = accept ? (iter ? BUSY : DONE) :
              (st == BUSY) ? ((cnt == '0) ? DONE : BUSY) :
              ((st == DONE) && out_ready) ? IDLE : st;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            st <= IDLE;
        else
            st <= nxt;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cnt <= '0;
            op <= '0;
            a <= '0;
            b <= '0;
            q <= '0;
            result <= '0;
            flags <= '0;
            dz <= 1'b0;
        end else if (accept && iter) begin
            op <= cmd;
            cnt <= CW'(WIDTH - 1);
            a <= '0;
            b <= (cmd == 4'b0011) ? in1 : in2;
            q <= (cmd == 4'b0011) ? in2 : in1;
        end else if (accept) begin
            result <= res;
            flags <= {res[WIDTH-1], res == '0, c, v};
            dz <= 1'b0;
        end else if (st == BUSY) begin
            a <= a_n;
            b <= b_n;
            q <= q_n;
            cnt <= cnt - CW'(1);
            if (cnt == '0) begin
                result <= fin;
                flags <= {fin[WIDTH-1], fin == '0, 2'b00};
                dz <= !is_mul && (b == '0);
            end
        end
endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, registered successor to the single-cycle datapath ALU. Keeps the existing 4-bit command encoding and adds three iterative operations: multiply, unsigned divide and unsigned remainder. Adds NZCV status flags and a valid/ready handshake on both sides, so the execute stage can stall on multi-cycle operations. It sits in the execute stage between operand forwarding and the EX/MEM register.

## Interface
- WIDTH, 32, operand/result width; legal values ≥ 4.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  operands and command valid.
- in_ready  out  1  block can accept an operation this cycle.
- cmd  in  4  operation select.
- in1  in  WIDTH  first operand.
- in2  in  WIDTH  second operand or shift amount.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  registered result.
- flags  out  4  {N,Z,C,V}, registered with result.
- dz  out  1  divide-by-zero marker, registered with result.
- busy  out  1  high while an iterative operation runs.

## Operation
- Command encoding:
  - 0000 add; 0010 sub (in1−in2).
  - 0100 and; 0101 or; 0110 nor; 0111 xor.
  - 1000 sll; 1001 sra; 1010 srl.
  - 1100 pass in2; 1101 pass in1.
  - New: 0011 mul (low WIDTH bits of the product); 1011 divu quotient; 1110 remu remainder.
  - Any other code gives result 0 and flags Z=1, others 0.
- Shifts use the full in2 value as the amount. For in2 ≥ WIDTH: sll and srl give 0; sra gives WIDTH copies of in1[WIDTH-1].
- Flags:
  - N = result[WIDTH-1]; Z = (result == 0).
  - add: C = carry-out; V = signed overflow.
  - sub: C = no-borrow (in1 ≥ in2 unsigned); V = signed overflow.
  - All other commands: C = V = 0.
- mul: shift-add, one multiplier bit per cycle, low WIDTH bits kept. Signed and unsigned results are identical.
- divu/remu: restoring division, one quotient bit per cycle.
  - Divisor 0 needs no special path and naturally yields quotient all-ones, remainder = in1.
  - dz = 1 for divu/remu when in2 == 0; otherwise dz = 0.
- FSM states: IDLE, BUSY, DONE.
  - IDLE, accept of a single-cycle op → DONE.
  - IDLE, accept of mul/divu/remu → BUSY; load operands; iteration counter = WIDTH−1.
  - BUSY: one iteration per cycle; counter decrements; at counter 0 → DONE with result and flags written.
  - DONE, out_ready=1 with no new accept → IDLE.
  - DONE, out_ready=1 with a new accept → DONE (single-cycle op) or BUSY (iterative op).
  - DONE, out_ready=0 → stay in DONE; result, flags and dz held stable.
- in_ready = rst_n & (state==IDLE | (state==DONE & out_ready)).
- An operation is accepted when in_valid & in_ready. Operands and cmd are sampled only at acceptance; they are don't-care at all other times.
- busy = (state == BUSY).
- out_valid = (state == DONE).

## Timing
- Reset (asynchronous, rst_n low):
  - state = IDLE; result = 0; flags = 0; dz = 0; counter = 0.
  - out_valid = 0; busy = 0; in_ready = 0.
  - An in-flight operation is discarded with no output.
- First acceptance is possible in the first cycle after rst_n rises.
- Single-cycle ops: out_valid rises the cycle after acceptance (latency 1). Throughput is 1 per cycle while out_ready stays high.
- Iterative ops: latency WIDTH+1 cycles from acceptance to out_valid. busy is high for WIDTH cycles. in_ready = 0 throughout.
- The out_ready → in_ready path is combinational. No other combinational input-to-output path exists.
- No reordering: results leave in acceptance order, one outstanding operation maximum.

## Test plan
- Add overflow (WIDTH=32): add 0x7FFFFFFF + 0x00000001 → result 0x80000000, flags N=1 Z=0 C=0 V=1, out_valid exactly 1 cycle after acceptance.
- Sub and borrow: sub 5−5 → 0 with Z=1 C=1. Then sub 0−1 → 0xFFFFFFFF with N=1 C=0 V=0. Issue both back-to-back with out_ready=1: two results on consecutive cycles.
- Shift boundaries:
  - sra 0x80000000 by 40 → 0xFFFFFFFF.
  - srl 0x80000000 by 32 → 0.
  - sll 0x1 by 31 → 0x80000000, N=1.
  - Undefined cmd 1111 → 0, Z=1.
- Multiply: mul 0x00010000 × 0x00010001 → 0x00010000. busy high 32 cycles, out_valid at cycle 33, in_ready low throughout.
- Divide:
  - divu 100/7 → 14; remu 100/7 → 2.
  - divu 0x1234/0 → 0xFFFFFFFF with dz=1; remu 0x1234/0 → 0x1234 with dz=1.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles after a result: result, flags and out_valid stay stable, in_ready=0.
  - Assert rst_n=0 during cycle 10 of a mul: all outputs zero immediately. After release, a new add 2+3 returns 5 with no trace of the aborted mul.
